// File: rtl/stoper_ctrl.sv
// Run-control sequencer for the BCD stopwatch: button edges, prescaled count enable, display path.
// Define STOPER_CTRL_OVF_EN to stop and flag sticky overflow when the counter would wrap.
module stoper_ctrl #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start_stop,
    input  logic        i_lap,
    input  logic        i_clear,
    input  logic [23:0] i_bcd_time,
    output logic        o_cnt_en,
    output logic        o_cnt_clr,
    output logic [23:0] o_disp_bcd,
    output logic [1:0]  o_state,
    output logic        o_ovf
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StLap  = 2'd2,
        StStop = 2'd3
    } state_e;

    localparam logic [15:0] DivLast = 16'(TICK_DIV - 1);

    state_e      state_q;
    logic        ss_q, lap_q, clr_q;
    logic [15:0] div_cnt_q;
    logic        cnt_en_q, cnt_clr_q;
    logic [23:0] disp_q;
    logic        ss_ev, lap_ev, clr_ev, running, ss_ok, ovf_hit;

    assign ss_ev   = i_start_stop & ~ss_q;
    assign lap_ev  = i_lap & ~lap_q;
    assign clr_ev  = i_clear & ~clr_q;
    assign running = (state_q == StRun) || (state_q == StLap);

`ifdef STOPER_CTRL_OVF_EN
    logic ovf_q;

    // The tick being issued now would roll 95:99:99 over, so stop instead.
    assign ovf_hit = cnt_en_q && (i_bcd_time == 24'h959999);
    assign ss_ok   = ss_ev & ~ovf_q;
    assign o_ovf   = ovf_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_hit) begin
            ovf_q <= 1'b1;
        end else if (clr_ev && (state_q == StStop)) begin
            ovf_q <= 1'b0;
        end
    end
`else
    assign ovf_hit = 1'b0;
    assign ss_ok   = ss_ev;
    assign o_ovf   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            ss_q      <= 1'b1;
            lap_q     <= 1'b1;
            clr_q     <= 1'b1;
            div_cnt_q <= 16'd0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            disp_q    <= 24'h0;
        end else begin
            ss_q      <= i_start_stop;
            lap_q     <= i_lap;
            clr_q     <= i_clear;
            cnt_clr_q <= 1'b0;
            cnt_en_q  <= running && (div_cnt_q == DivLast);
            disp_q    <= i_bcd_time;

            // Prescaler keeps its phase across STOP so a resume finishes the partial tick.
            unique case (state_q)
                StRun, StLap: div_cnt_q <= (div_cnt_q == DivLast) ? 16'd0 : div_cnt_q + 16'd1;
                StStop:       div_cnt_q <= div_cnt_q;
                StIdle:       div_cnt_q <= 16'd0;
            endcase

            // Events are checked in priority order, skipping those illegal in the state.
            unique case (state_q)
                StIdle: begin
                    if (ss_ev) begin
                        state_q <= StRun;
                    end else begin
                        disp_q <= 24'h0;
                    end
                end
                StRun: begin
                    if (ss_ev) begin
                        state_q <= StStop;
                    end else if (lap_ev) begin
                        state_q <= StLap;
                    end
                end
                StLap: begin
                    if (ss_ev) begin
                        state_q <= StStop;
                    end else if (lap_ev) begin
                        state_q <= StRun;
                    end else begin
                        disp_q <= disp_q;
                    end
                end
                StStop: begin
                    if (clr_ev) begin
                        state_q   <= StIdle;
                        cnt_clr_q <= 1'b1;
                        disp_q    <= 24'h0;
                    end else if (ss_ok) begin
                        state_q <= StRun;
                    end
                end
            endcase

            if (ovf_hit) begin
                state_q <= StStop;
                disp_q  <= i_bcd_time;
            end
        end
    end

    assign o_cnt_en   = cnt_en_q;
    assign o_cnt_clr  = cnt_clr_q;
    assign o_disp_bcd = disp_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_stoper_ctrl.sv
// Bench for stoper_ctrl: directed scenarios plus random button traffic against a behavioural model.
module tb_stoper_ctrl;

    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss, lap, clr;
    logic [23:0] bcd;
    logic        cnt_en, cnt_clr, ovf;
    logic [23:0] disp;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    // Model: 0 idle, 1 run, 2 lap, 3 stop; run_cycles counts running cycles since idle.
    int          m_state;
    int          m_run_cycles;
    logic        m_en, m_clr, m_ovf;
    logic [23:0] m_disp;
    logic        m_pss, m_plap, m_pclr;

    stoper_ctrl #(.TICK_DIV(TDIV)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start_stop (ss),
        .i_lap        (lap),
        .i_clear      (clr),
        .i_bcd_time   (bcd),
        .o_cnt_en     (cnt_en),
        .o_cnt_clr    (cnt_clr),
        .o_disp_bcd   (disp),
        .o_state      (state),
        .o_ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic l, input logic c,
                              input logic [23:0] b);
        bit ev_ss, ev_lap, ev_clr, fire, hit;
        int ns;
        logic nclr;
        if (r) begin
            m_state = 0; m_run_cycles = 0; m_en = 0; m_clr = 0; m_ovf = 0; m_disp = 0;
            m_pss = 1; m_plap = 1; m_pclr = 1;
            return;
        end
        ev_ss  = s && !m_pss;
        ev_lap = l && !m_plap;
        ev_clr = c && !m_pclr;
        m_pss = s; m_plap = l; m_pclr = c;
        fire = (m_state == 1 || m_state == 2) && (m_run_cycles % TDIV == TDIV - 1);
`ifdef STOPER_CTRL_OVF_EN
        hit = m_en && (b == 24'h959999);
`else
        hit = 0;
`endif
        ns = m_state;
        nclr = 0;
        if (ev_clr && m_state == 3) begin
            ns = 0; nclr = 1; m_ovf = 0;
        end else if (ev_ss && !(m_state == 3 && m_ovf)) begin
            ns = (m_state == 1 || m_state == 2) ? 3 : 1;
        end else if (ev_lap && (m_state == 1 || m_state == 2)) begin
            ns = (m_state == 1) ? 2 : 1;
        end
        if (hit) begin
            ns = 3; m_ovf = 1;
        end
        if (m_state == 0) m_run_cycles = 0;
        else if (m_state != 3) m_run_cycles++;
        m_en  = fire;
        m_clr = nclr;
        if (ns == 0) m_disp = 0;
        else if (!(m_state == 2 && ns == 2)) m_disp = b;
        m_state = ns;
    endtask

    task automatic step(input logic r, input logic s, input logic l, input logic c,
                        input logic [23:0] b);
        rst = r; ss = s; lap = l; clr = c; bcd = b;
        @(posedge clk);
        model_edge(r, s, l, c, b);
        #1;
        check_val("state", 24'(state), 24'(m_state));
        check_val("cnt_en", 24'(cnt_en), 24'(m_en));
        check_val("cnt_clr", 24'(cnt_clr), 24'(m_clr));
        check_val("disp", disp, m_disp);
        check_val("ovf", 24'(ovf), 24'(m_ovf));
    endtask

    task automatic idle(input int n, input logic [23:0] b);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, b);
    endtask

    initial begin
        logic [23:0] rb;
        rst = 1; ss = 0; lap = 0; clr = 0; bcd = 0;
        #1;
        step(1, 0, 0, 0, 24'h000042);
        step(1, 0, 0, 0, 24'h000042);
        idle(3, 24'h000042);

        // Basic run then stop
        step(0, 1, 0, 0, 24'h000001);
        idle(40, 24'h000002);
        step(0, 1, 0, 0, 24'h000003);
        idle(10, 24'h000004);
        check_val("stopped", 24'(state), 24'd3);

        // Lap freeze while the count advances
        step(0, 1, 0, 0, 24'h000100);
        idle(5, 24'h000110);
        step(0, 0, 1, 0, 24'h000123);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 24'h000124 + 24'(i));
        check_val("lap_frozen", disp, 24'h000123);
        step(0, 0, 1, 0, 24'h000200);
        idle(3, 24'h000201);

        // Stop, then clear and start_stop together
        step(0, 1, 0, 0, 24'h000300);
        idle(2, 24'h000300);
        step(0, 1, 0, 1, 24'h000300);
        idle(3, 24'h000300);
        check_val("cleared", 24'(state), 24'd0);

        // Ignored events and a held button
        step(0, 1, 0, 0, 24'h000400);
        step(0, 0, 0, 1, 24'h000401);
        idle(2, 24'h000402);
        step(0, 1, 0, 0, 24'h000403);
        step(0, 0, 1, 0, 24'h000404);
        idle(2, 24'h000405);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 24'h000406);
        idle(2, 24'h000407);
        // Back-to-back 1,0,1 gives two events
        step(0, 1, 0, 0, 24'h000408);
        step(0, 0, 0, 0, 24'h000408);
        step(0, 1, 0, 0, 24'h000408);
        idle(2, 24'h000409);

        // Resume keeps prescaler phase
        step(0, 0, 0, 1, 24'h0);
        step(0, 0, 0, 0, 24'h0);
        step(0, 1, 0, 0, 24'h000500);
        idle(5, 24'h000500);
        step(0, 1, 0, 0, 24'h000500);
        idle(20, 24'h000500);
        step(0, 1, 0, 0, 24'h000500);
        idle(8, 24'h000500);

        // Button held across reset deassertion
        step(1, 1, 0, 0, 24'h000600);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 24'h000600);
        check_val("held_reset", 24'(state), 24'd0);
        idle(2, 24'h000600);

        // Overflow value reached while running
        step(0, 1, 0, 0, 24'h959990);
        for (int i = 0; i < 3 * TDIV; i++) step(0, 0, 0, 0, 24'h959999);
        step(0, 1, 0, 0, 24'h959999);
        idle(2, 24'h959999);
        step(0, 0, 0, 1, 24'h959999);
        idle(3, 24'h000000);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rb = ($urandom_range(0, 15) == 0) ? 24'h959999 : 24'($urandom());
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stoper_ctrl.md
# stoper_ctrl

Run-control sequencer for the BCD stopwatch counter. It turns debounced start/stop, lap and clear button levels into a prescaled count-enable and a clear pulse for the counter. It also owns the display path, either following the live count or freezing a lap time, and reports the run state to the top level.

## Interface
Parameters:
- TICK_DIV, default 100: i_clk cycles per counter increment; legal range 2..65535.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start_stop  input  1  debounced, synchronised button level; acts on its 0->1 edge.
- i_lap  input  1  debounced, synchronised button level; acts on its 0->1 edge.
- i_clear  input  1  debounced, synchronised button level; acts on its 0->1 edge.
- i_bcd_time  input  24  current BCD value from the stopwatch counter (6 digits).
- o_cnt_en  output  1  one-cycle increment-enable pulse to the counter.
- o_cnt_clr  output  1  one-cycle clear pulse to the counter.
- o_disp_bcd  output  24  BCD value for the display driver.
- o_state  output  2  IDLE=0, RUN=1, LAP=2, STOP=3.
- o_ovf  output  1  sticky overflow flag; tied 0 unless STOPER_CTRL_OVF_EN is defined.

## Operation
- Edge detect: one delay register per button input. An event is `in & ~in_d`.
- Event priority in one cycle: clear > start_stop > lap. Only the highest-priority event that is legal in the current state is acted on; all others are dropped.
- FSM transitions:
  - IDLE: start_stop -> RUN. Lap and clear are ignored.
  - RUN: start_stop -> STOP. Lap -> LAP, and o_disp_bcd latches the current i_bcd_time.
  - LAP: counting continues and the display stays frozen. Lap -> RUN (display follows again). Start_stop -> STOP (display follows again). Clear is ignored.
  - STOP: start_stop -> RUN. Clear -> IDLE with an o_cnt_clr pulse. Lap is ignored.
- Prescaler (div_cnt, 16 bit):
  - Increments every cycle in RUN or LAP and wraps from TICK_DIV-1 to 0.
  - Holds its value in STOP, so resuming keeps the partial tick phase.
  - Zeroed in IDLE.
- o_cnt_en is registered: it rises one cycle after any cycle in which state is RUN/LAP and div_cnt == TICK_DIV-1. The result is exactly one pulse per TICK_DIV running cycles.
- Display:
  - Outside LAP, o_disp_bcd is i_bcd_time registered, with one cycle of latency.
  - In LAP, o_disp_bcd holds the captured value.
  - In IDLE, o_disp_bcd is forced to 0.

## Timing
- Reset values:
  - o_state = IDLE; o_cnt_en = 0; o_cnt_clr = 0; o_disp_bcd = 24'h0; o_ovf = 0; div_cnt = 0.
  - The button delay registers reset to 1, so a button held through reset produces no event.
- An event seen at clock edge k updates o_state at edge k, visible in cycle k+1.
- Leaving LAP frees the display immediately: o_disp_bcd tracks i_bcd_time from edge k.
- o_cnt_clr is high for exactly the cycle after the clear event edge.
- First o_cnt_en after IDLE->RUN comes TICK_DIV cycles after the transition edge.
- A button held high produces one event only. Releasing it and pressing again produces a new event, even on back-to-back cycles (1,0,1).
- i_rst asserted in any state returns all registers to reset values at the next edge. It does not by itself generate o_cnt_clr.

## Configuration
- STOPER_CTRL_OVF_EN defined:
  - If o_cnt_en is being issued while i_bcd_time == 24'h959999, the controller forces the state to STOP on the same edge and sets o_ovf.
  - While o_ovf = 1, start_stop is ignored. Clear goes to IDLE and clears o_ovf.
- STOPER_CTRL_OVF_EN undefined:
  - o_ovf is constant 0 and there is no overflow check.
  - The counter wraps 95:99:99 -> 00:00:00 and the controller keeps running.

## Test plan
- Basic run, TICK_DIV=4: reset, pulse start_stop. Expect o_state=1, o_cnt_en pulses every 4th cycle, first pulse 4 cycles after the transition. After 40 cycles, pulse start_stop. Expect o_state=3 and no further o_cnt_en pulses.
- Lap freeze: i_bcd_time=24'h000123 at the lap edge. Expect o_state=2 and o_disp_bcd to stay 24'h000123 while i_bcd_time advances and o_cnt_en keeps pulsing. A second lap gives o_state=1 and the display follows again.
- Clear: in STOP, raise i_clear and i_start_stop in the same cycle. Expect a single 1-cycle o_cnt_clr, o_state=0, o_disp_bcd=0, and no transition to RUN.
- Ignored and held events:
  - Clear in RUN and lap in STOP cause no state change.
  - start_stop held high for 10 cycles toggles state exactly once.
  - start_stop high across reset deassertion causes no event.
- Resume phase: stop when div_cnt=2, wait 20 cycles, restart. Expect the next o_cnt_en 2 cycles after the restart edge.
- Overflow (STOPER_CTRL_OVF_EN): drive i_bcd_time=24'h959999 in RUN. At the tick, expect o_state=3 and o_ovf=1. start_stop is ignored; clear gives o_ovf=0 and o_state=0. Without the macro, o_ovf stays 0 and the state stays 1.
